// File: rtl/pipe_skid_buf_if.sv
// Valid/ready stream bundle for pipe_skid_buf: upstream (s_*) and downstream (m_*) sides plus occupancy.
// The slave modport is the buffer's own view; master is the view of whatever drives it.
interface pipe_skid_buf_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  s_valid_i;
    logic                  s_ready_o;
    logic [DATA_WIDTH-1:0] s_data_i;
    logic                  m_valid_o;
    logic                  m_ready_i;
    logic [DATA_WIDTH-1:0] m_data_o;
    logic [1:0]            level_o;

    modport master (
        output s_valid_i, s_data_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o, level_o
    );

    modport slave (
        input  s_valid_i, s_data_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o, level_o
    );
endinterface

// File: rtl/pipe_skid_buf.sv
// Two-entry skid buffer: every output (data, valid, ready) is decoded from registers only,
// so no combinational path crosses the slice in either direction.
module pipe_skid_buf #(
    parameter int DATA_WIDTH = 32
) (
    input logic           clk_i,
    input logic           rst_n_i,
    pipe_skid_buf_if.slave bus
);

    // The state encoding doubles as the occupancy count driven on level_o.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    state_e                state_q;
    logic [DATA_WIDTH-1:0] main_q;
    logic [DATA_WIDTH-1:0] skid_q;
    logic                  s_hs;
    logic                  m_hs;

    assign bus.s_ready_o = (state_q != FULL);
    assign bus.m_valid_o = (state_q != EMPTY);
    assign bus.m_data_o  = main_q;
    assign bus.level_o   = state_q;

    assign s_hs = bus.s_valid_i & bus.s_ready_o;
    assign m_hs = bus.m_valid_o & bus.m_ready_i;

    // NOTE: sequential state uses <= so every register samples pre-edge values regardless of statement order.
    // NOTE: both data entries are reset too, since m_data_o must read 0 the moment reset asserts.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (s_hs) begin
                        main_q  <= bus.s_data_i;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_hs && m_hs) begin
                        main_q <= bus.s_data_i;
                    end else if (s_hs) begin
                        skid_q  <= bus.s_data_i;
                        state_q <= FULL;
                    end else if (m_hs) begin
                        state_q <= EMPTY;
                    end
                end
                FULL: begin
                    if (m_hs) begin
                        main_q  <= skid_q;
                        state_q <= BUSY;
                    end
                end
                // Code 3 cannot be reached legally; recover to a clean empty slice.
                default: state_q <= EMPTY;
            endcase
        end
    end

`ifndef SV_ASSRT_DISABLE
    a_no_x_ctrl : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !$isunknown({bus.s_valid_i, bus.m_ready_i}));

    a_stall_stable : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        (bus.m_valid_o && !bus.m_ready_i) |=> (bus.m_valid_o && $stable(bus.m_data_o)));
`endif

endmodule

// File: tb/tb_pipe_skid_buf.sv
// Directed vector table plus reset sequences and a randomized scoreboard run for pipe_skid_buf.
module tb_pipe_skid_buf;

    localparam int DW = 32;

    logic clk_i;
    logic rst_n_i;
    int   n_checks;
    int   n_fails;

    pipe_skid_buf_if #(.DATA_WIDTH(DW)) bus ();

    pipe_skid_buf #(.DATA_WIDTH(DW)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .bus     (bus.slave)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          sv;
        logic          mr;
        logic [DW-1:0] d;
        logic          ev;
        logic          er;
        logic [1:0]    el;
        logic [DW-1:0] ed;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outs(input string tag, input logic ev, input logic er,
                              input logic [1:0] el, input logic [DW-1:0] ed);
        check({tag, " m_valid"}, {31'd0, bus.m_valid_o}, {31'd0, ev});
        check({tag, " s_ready"}, {31'd0, bus.s_ready_o}, {31'd0, er});
        check({tag, " level"},   {30'd0, bus.level_o},   {30'd0, el});
        check({tag, " m_data"},  bus.m_data_o,           ed);
    endtask

    task automatic add(input logic sv, input logic mr, input logic [DW-1:0] d,
                       input logic ev, input logic er, input logic [1:0] el, input logic [DW-1:0] ed);
        vec_t v;
        v.sv = sv; v.mr = mr; v.d = d; v.ev = ev; v.er = er; v.el = el; v.ed = ed;
        vecs.push_back(v);
    endtask

    // Drive inputs, cross one rising edge, settle just after it.
    task automatic step(input logic sv, input logic mr, input logic [DW-1:0] d);
        bus.s_valid_i = sv;
        bus.m_ready_i = mr;
        bus.s_data_i  = d;
        @(posedge clk_i);
        #1;
    endtask

    // Assert reset mid-cycle, check the immediate effect, hold across an edge, release.
    task automatic mid_reset(input string tag);
        #4;
        rst_n_i = 1'b0;
        #1;
        check_outs({tag, " async"}, 1'b0, 1'b1, 2'd0, '0);
        step(1'b0, 1'b0, 32'hDEAD_BEEF);
        check_outs({tag, " held"}, 1'b0, 1'b1, 2'd0, '0);
        rst_n_i = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] sb[$];
        int            cnt;
        n_checks = 0;
        n_fails  = 0;
        rst_n_i  = 1'b0;
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b0;
        bus.s_data_i  = '0;

        // Continuous stream: one beat per cycle, level stays 1.
        for (int i = 1; i <= 8; i++) add(1, 1, DW'(i), 1, 1, 2'd1, DW'(i));
        add(0, 1, 32'h0, 0, 1, 2'd0, 32'h08);
        // Backpressure: A3 is refused while full, then taken once space opens.
        add(1, 0, 32'hA1, 1, 1, 2'd1, 32'hA1);
        add(1, 0, 32'hA2, 1, 0, 2'd2, 32'hA1);
        add(1, 0, 32'hA3, 1, 0, 2'd2, 32'hA1);
        add(1, 1, 32'hA3, 1, 1, 2'd1, 32'hA2);
        add(1, 1, 32'hA3, 1, 1, 2'd1, 32'hA3);
        add(0, 1, 32'h0,  0, 1, 2'd0, 32'hA3);
        // Idle data is ignored and a stalled beat holds.
        add(1, 0, 32'h11, 1, 1, 2'd1, 32'h11);
        add(0, 0, 32'h99, 1, 1, 2'd1, 32'h11);
        add(0, 1, 32'h99, 0, 1, 2'd0, 32'h11);
        // Single-cycle stall at 0x05: skid absorbs 0x06, flow resumes.
        for (int i = 1; i <= 5; i++) add(1, 1, DW'(i), 1, 1, 2'd1, DW'(i));
        add(1, 0, 32'h06, 1, 0, 2'd2, 32'h05);
        add(1, 1, 32'h07, 1, 1, 2'd1, 32'h06);
        add(1, 1, 32'h07, 1, 1, 2'd1, 32'h07);
        add(1, 1, 32'h08, 1, 1, 2'd1, 32'h08);
        add(0, 1, 32'h0,  0, 1, 2'd0, 32'h08);

        #12;
        check_outs("por", 1'b0, 1'b1, 2'd0, '0);
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;

        foreach (vecs[i]) begin
            step(vecs[i].sv, vecs[i].mr, vecs[i].d);
            check_outs($sformatf("vec%0d", i), vecs[i].ev, vecs[i].er, vecs[i].el, vecs[i].ed);
        end

        // Reset while busy with a nonzero payload.
        step(1, 0, 32'h5A);
        check_outs("busy pre", 1'b1, 1'b1, 2'd1, 32'h5A);
        mid_reset("rst busy");

        // Reset while full: B1/B2 must vanish, C1 is the first beat out.
        step(1, 0, 32'hB1);
        step(1, 0, 32'hB2);
        check_outs("full pre", 1'b1, 1'b0, 2'd2, 32'hB1);
        mid_reset("rst full");
        step(1, 1, 32'hC1);
        check_outs("post rst C1", 1'b1, 1'b1, 2'd1, 32'hC1);
        step(0, 1, 32'h0);
        check_outs("post rst drain", 1'b0, 1'b1, 2'd0, 32'hC1);

        // Random traffic against a queue model of the two entries.
        cnt = 0;
        for (int c = 0; c < 10000; c++) begin
            logic          sv;
            logic          mr;
            logic [DW-1:0] d;
            logic          shs;
            logic          mhs;
            check("rnd level", {30'd0, bus.level_o}, DW'(cnt));
            check("rnd s_ready", {31'd0, bus.s_ready_o}, {31'd0, (bus.level_o != 2'd2)});
            check("rnd m_valid", {31'd0, bus.m_valid_o}, {31'd0, (cnt != 0)});
            if (cnt != 0) check("rnd m_data", bus.m_data_o, sb[0]);
            sv  = 1'($urandom_range(0, 1));
            mr  = 1'($urandom_range(0, 1));
            d   = $urandom;
            shs = sv && (cnt != 2);
            mhs = mr && (cnt != 0);
            if (mhs) begin
                void'(sb.pop_front());
                cnt--;
            end
            if (shs) begin
                sb.push_back(d);
                cnt++;
            end
            step(sv, mr, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
